bishift_feeder: RTL
===================

# bishift_feeder

Upstream serial driver for the 4-bit bidirectional shift register. It accepts one parallel word plus a direction over a valid/ready handshake, then drives `en`, `dir`, `sin_l` and `sin_r` for exactly WIDTH cycles, so that the word lands intact in the shift register's `q`. It then pulses `done` and returns to idle.

## Interface
- `WIDTH`, 4, bits per word; must equal the downstream shift-register width; minimum 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  word and direction present on `in_data`/`in_dir`.
- `in_ready`  output  1  feeder can accept a word this cycle.
- `in_data`  input  WIDTH  parallel word to serialize.
- `in_dir`  input  1  1 = feed via `sin_r`; 0 = feed via `sin_l`.
- `en`  output  1  shift enable to the downstream register.
- `dir`  output  1  direction to the downstream register.
- `sin_l`  output  1  serial bit, left input.
- `sin_r`  output  1  serial bit, right input.
- `busy`  output  1  high while in SHIFT or DONE.
- `done`  output  1  one-cycle pulse after the last shift.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on `in_valid && in_ready`.
  - SHIFT -> DONE when the bit counter reaches WIDTH-1 on an active cycle.
  - DONE -> IDLE unconditionally.
- `in_ready` = (state == IDLE), combinational from state. It is never high in SHIFT or DONE.
- On accept, the feeder captures `in_data` into an internal WIDTH-bit holding register and captures `in_dir`. The bit counter (width `$clog2(WIDTH)`) clears to 0.
- Downstream convention:
  - `sin_r` enters the register's MSB and shifts toward the LSB, so dir=1 sends `in_data` LSB first.
  - `sin_l` enters the register's LSB and shifts toward the MSB, so dir=0 sends MSB first.
  - After WIDTH shifts, `q == in_data` in both directions.
- In SHIFT, every cycle:
  - `en` = 1 and `dir` = the captured direction.
  - The active serial line carries the current bit; the inactive serial line is held at 0.
  - The counter increments.
- In IDLE and DONE: `en`=0, `sin_l`=0, `sin_r`=0. `dir` holds its last value.
- `in_valid` while `in_ready`=0 is ignored. The upstream source holds the word until it sees `in_ready`.
- Reset (`rst`=0 at a clock edge), from any state including mid-SHIFT:
  - state -> IDLE, counter -> 0, holding register -> 0.
  - All outputs go to their reset values. A partially fed word is abandoned and no `done` is issued.

## Timing
- Reset values: `en`=0, `dir`=0, `sin_l`=0, `sin_r`=0, `busy`=0, `done`=0. `in_ready`=1 from the first cycle after reset releases.
- `en`, `dir`, `sin_l`, `sin_r`, `done` and `busy` are registered outputs.
- Word accepted at edge k:
  - `en`=1 during cycles k+1 .. k+WIDTH.
  - `done`=1 during cycle k+WIDTH+1.
  - `in_ready` returns high at cycle k+WIDTH+2.
- Throughput is one word per WIDTH+2 cycles.
- The downstream register samples each bit at the edge ending its cycle. Its `q` equals `in_data` after edge k+WIDTH+1.

## Configuration
- `BISHIFT_FEEDER_PAUSE_EN` defined: adds input `pause` (1 bit).
  - While `pause`=1 in SHIFT: `en`=0, the counter and current bit freeze, and the state holds.
  - `pause` has no effect in IDLE or DONE. Latency grows by the number of paused cycles.
- Macro undefined: no `pause` port, and every SHIFT cycle is active.

## Structure
- Shared package `bishift_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - `DIR_LEFT`=1'b0 and `DIR_RIGHT`=1'b1;
  - the default width constant `BISHIFT_W`=4.
- Single module. The only natural split is the bit counter, as sub-module `bishift_bitcnt`; keeping it inline is also acceptable.

## Test plan
- WIDTH=4, accept `in_data`=4'b1011, `in_dir`=1 -> `sin_r` = 1,1,0,1 on four consecutive `en` cycles; `sin_l`=0 throughout; `done` pulses on the 5th cycle; downstream `q`=1011.
- Accept 4'b1011 with `in_dir`=0 -> `sin_l` = 1,0,1,1; `sin_r`=0; `dir`=0 during shifts; `q`=1011.
- Hold `in_valid`=1 with a new word during SHIFT -> `in_ready`=0 and no capture. The new word is accepted exactly at cycle k+6, giving back-to-back throughput of 6 cycles per word.
- Drive `rst`=0 after the 2nd shift cycle -> next cycle `en`=0, `busy`=0, `done` never pulses, `in_ready`=1 after release.
- Reset sequence -> all outputs 0 during reset; `in_ready`=1 in the first post-release cycle.
- With `BISHIFT_FEEDER_PAUSE_EN`, pause for 2 cycles mid-word -> `en`=0 for those 2 cycles, the bit sequence is unchanged, and `done` arrives 2 cycles later (cycle k+7).

Source files
------------

// File: rtl/bishift_pkg.sv
// ============================================================================
// Module      : bishift_pkg
// Description : Shared types and constants for the bidirectional shift
//               register feeder (state encoding, direction codes, width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bishift_pkg;

    // Feeder state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Direction codes as seen by the downstream shift register
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Default downstream register width
    localparam int BISHIFT_W = 4;

endpackage : bishift_pkg

`default_nettype wire

// File: rtl/bishift_bitcnt.sv
// ============================================================================
// Module      : bishift_bitcnt
// Description : Bit-position counter for the feeder. Exposes the next-state
//               value so the feeder can pre-select the bit it will drive on
//               the following cycle, plus a flag marking the final position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bishift_bitcnt
    import bishift_pkg::*;
#(
    parameter  int WIDTH = BISHIFT_W,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_next_o,
    output logic          last_o
);

    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on word accept, advance after each consumed bit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next_o = cnt_d;
    assign last_o     = (cnt_q == LAST_POS);

endmodule : bishift_bitcnt

`default_nettype wire

// File: rtl/bishift_feeder.sv
// ============================================================================
// Module      : bishift_feeder
// Description : Serial driver for a WIDTH-bit bidirectional shift register.
//               Accepts a word + direction over valid/ready, drives en/dir
//               and the selected serial line for WIDTH active cycles so the
//               word lands intact in the downstream q, then pulses done.
//               Optional: define BISHIFT_FEEDER_PAUSE_EN to add a 'pause'
//               input that stalls shifting while high in SHIFT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bishift_feeder
    import bishift_pkg::*;
#(
    parameter  int WIDTH = BISHIFT_W,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             en,
    output logic             dir,
    output logic             sin_l,
    output logic             sin_r,
    output logic             busy,
    output logic             done
`ifdef BISHIFT_FEEDER_PAUSE_EN
    ,
    input  logic             pause
`endif
);

    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   hold_q;
    logic               en_q;
    logic               dir_q;
    logic               sin_l_q;
    logic               sin_r_q;
    logic               busy_q;
    logic               done_q;

    logic               w_pause;
    logic               w_accept;
    logic               w_cnt_inc;
    logic [CW-1:0]      w_cnt_next;
    logic               w_cnt_last;
    logic [WIDTH-1:0]   w_src_word;
    logic               w_src_dir;
    logic               w_bit;

`ifdef BISHIFT_FEEDER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Counter advances only after a cycle in which en was actually asserted
    bishift_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_accept),
        .inc_i      (w_cnt_inc),
        .cnt_next_o (w_cnt_next),
        .last_o     (w_cnt_last)
    );

    // Select the bit to present next: LSB-first toward sin_r, MSB-first toward sin_l
    always_comb begin
        w_accept   = (state_q == ST_IDLE) && in_valid;
        w_cnt_inc  = (state_q == ST_SHIFT) && en_q;
        w_src_word = w_accept ? in_data : hold_q;
        w_src_dir  = w_accept ? in_dir  : dir_q;
        if (w_src_dir == DIR_RIGHT) begin
            w_bit = w_src_word[w_cnt_next];
        end else begin
            w_bit = w_src_word[LAST_POS - w_cnt_next];
        end
    end

    // Control FSM with all handshake-facing outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            en_q    <= 1'b0;
            dir_q   <= DIR_LEFT;
            sin_l_q <= 1'b0;
            sin_r_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (w_accept) begin
                        state_q <= ST_SHIFT;
                        hold_q  <= in_data;
                        dir_q   <= in_dir;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        sin_r_q <= (in_dir == DIR_RIGHT) && w_bit;
                        sin_l_q <= (in_dir == DIR_LEFT)  && w_bit;
                    end
                end
                ST_SHIFT: begin
                    if (en_q && w_cnt_last) begin
                        // Final bit consumed at this edge
                        state_q <= ST_DONE;
                        en_q    <= 1'b0;
                        sin_l_q <= 1'b0;
                        sin_r_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        en_q    <= !w_pause;
                        sin_r_q <= (dir_q == DIR_RIGHT) && w_bit;
                        sin_l_q <= (dir_q == DIR_LEFT)  && w_bit;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    sin_l_q <= 1'b0;
                    sin_r_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign en       = en_q;
    assign dir      = dir_q;
    assign sin_l    = sin_l_q;
    assign sin_r    = sin_r_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : bishift_feeder

`default_nettype wire
